// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tlb_pkg
// Brief   : Shared types and constants for the TLB way array: permission
//           encoding, flush FSM states, default geometry and log2 helper.
// Rev     : 1.0  initial release
// ============================================================================
package tlb_pkg;

   // Default geometry
   localparam int unsigned TLB_DEF_NUM_SETS = 16;
   localparam int unsigned TLB_DEF_NUM_WAYS = 4;
   localparam int unsigned TLB_DEF_VPN_W    = 20;
   localparam int unsigned TLB_DEF_PPN_W    = 20;
   localparam int unsigned TLB_DEF_ASID_W   = 8;

   // Permission bits carried with each entry
   typedef enum logic [1:0] {
      PERM_NONE = 2'b00,
      PERM_R    = 2'b01,
      PERM_W    = 2'b10,
      PERM_RW   = 2'b11
   } tlb_perm_e;

   // Invalidation sweep states
   typedef enum logic {
      FL_IDLE  = 1'b0,
      FL_SWEEP = 1'b1
   } tlb_flush_state_e;

   // Index width helper for power-of-two counts
   function automatic int unsigned tlb_log2(input int unsigned n);
      return $clog2(n);
   endfunction

   localparam int unsigned TLB_DEF_WAY_W = tlb_log2(TLB_DEF_NUM_WAYS);
   localparam int unsigned TLB_DEF_SET_W = tlb_log2(TLB_DEF_NUM_SETS);

endpackage
`default_nettype wire

// File: rtl/tlb_age_lru.sv
`default_nettype none
// ============================================================================
// Module  : tlb_age_lru
// Brief   : Age-based replacement for one set: picks the fill victim and
//           computes the ages after a hit or fill touches a way.
// Rev     : 1.0  initial release
// ============================================================================
module tlb_age_lru
   import tlb_pkg::*;
#(
   parameter int unsigned NUM_WAYS = TLB_DEF_NUM_WAYS,
   parameter int unsigned WAY_W    = tlb_log2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0]            valid_i,
   input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages_i,
   input  logic                           touch_i,
   input  logic                           is_fill_i,
   input  logic [WAY_W-1:0]               way_i,
   output logic [WAY_W-1:0]               victim_o,
   output logic [NUM_WAYS-1:0][WAY_W-1:0] ages_o
);

   localparam logic [WAY_W-1:0] AGE_OLDEST = WAY_W'(NUM_WAYS - 1);

   logic             w_found;
   logic [WAY_W-1:0] w_old_age;

   // Victim: lowest invalid way, else the lowest way holding the oldest age
   always_comb begin
      victim_o = '0;
      w_found  = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_found && !valid_i[w]) begin
            victim_o = WAY_W'(w);
            w_found  = 1'b1;
         end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_found && (ages_i[w] == AGE_OLDEST)) begin
            victim_o = WAY_W'(w);
            w_found  = 1'b1;
         end
      end
   end

   // Touched way becomes youngest; valid ways younger than it age by one
   always_comb begin
      w_old_age = is_fill_i ? AGE_OLDEST : ages_i[way_i];
      ages_o    = ages_i;
      if (touch_i) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == way_i) begin
               ages_o[w] = '0;
            end else if (valid_i[w] && (ages_i[w] < w_old_age)) begin
               ages_o[w] = ages_i[w] + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tlb_way_array.sv
`default_nettype none
// ============================================================================
// Module  : tlb_way_array
// Brief   : Set-associative TLB storage with one-cycle lookup, age-based
//           replacement on fill and a set-by-set invalidation sweep.
//           Define TLB_ASID_EN to store and match ASID/global per entry.
// Rev     : 1.0  initial release
// ============================================================================
module tlb_way_array
   import tlb_pkg::*;
#(
   parameter int unsigned NUM_SETS = TLB_DEF_NUM_SETS,
   parameter int unsigned NUM_WAYS = TLB_DEF_NUM_WAYS,
   parameter int unsigned VPN_W    = TLB_DEF_VPN_W,
   parameter int unsigned PPN_W    = TLB_DEF_PPN_W,
   parameter int unsigned ASID_W   = TLB_DEF_ASID_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          lk_valid,
   output logic                          lk_ready,
   input  logic [VPN_W-1:0]              lk_vpn,
   input  logic [ASID_W-1:0]             lk_asid,
   output logic                          rsp_valid,
   output logic                          rsp_hit,
   output logic [tlb_log2(NUM_WAYS)-1:0] rsp_way,
   output logic [PPN_W-1:0]              rsp_ppn,
   output logic [1:0]                    rsp_perms,
   input  logic                          fill_en,
   input  logic [VPN_W-1:0]              fill_vpn,
   input  logic [ASID_W-1:0]             fill_asid,
   input  logic                          fill_global,
   input  logic [PPN_W-1:0]              fill_ppn,
   input  logic [1:0]                    fill_perms,
   input  logic                          flush_req,
   input  logic                          flush_by_asid,
   input  logic [ASID_W-1:0]             flush_asid,
   output logic                          flush_busy,
   output logic                          flush_done
);

   localparam int unsigned WAY_W = tlb_log2(NUM_WAYS);
   localparam int unsigned SET_W = tlb_log2(NUM_SETS);

   logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0][WAY_W-1:0] age_q   [NUM_SETS];
   logic [NUM_WAYS-1:0][WAY_W-1:0] age_d   [NUM_SETS];
   logic [VPN_W-1:0]               vpn_q   [NUM_SETS][NUM_WAYS];
   logic [PPN_W-1:0]               ppn_q   [NUM_SETS][NUM_WAYS];
   logic [1:0]                     perms_q [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]               w_victim [NUM_SETS];

`ifdef TLB_ASID_EN
   logic [ASID_W-1:0]   asid_q [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] glob_q [NUM_SETS];
   logic                by_asid_q, by_asid_d;
   logic [ASID_W-1:0]   fl_asid_q, fl_asid_d;
`else
   logic w_unused_asid;
   assign w_unused_asid = ^{lk_asid, fill_asid, fill_global, flush_by_asid, flush_asid};
`endif

   tlb_flush_state_e state_q, state_d;
   logic [SET_W-1:0] sweep_q, sweep_d;
   logic             done_q, done_d;

   logic                rsp_valid_q, rsp_hit_q;
   logic [WAY_W-1:0]    rsp_way_q;
   logic [PPN_W-1:0]    rsp_ppn_q;
   logic [1:0]          rsp_perms_q;

   logic                w_idle, w_lk_fire, w_fill_fire, w_hit;
   logic [SET_W-1:0]    w_lk_set, w_fill_set;
   logic [WAY_W-1:0]    w_hit_way, w_fill_victim;
   logic [NUM_WAYS-1:0] w_asid_ok, w_match, w_inv_mask;

   assign w_idle        = (state_q == FL_IDLE);
   assign w_lk_fire     = lk_valid && w_idle;
   assign w_fill_fire   = fill_en && w_idle;
   assign w_lk_set      = lk_vpn[SET_W-1:0];
   assign w_fill_set    = fill_vpn[SET_W-1:0];
   assign w_fill_victim = w_victim[w_fill_set];

   // Tag compare across the ways of the looked-up set
   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef TLB_ASID_EN
         w_asid_ok[w] = glob_q[w_lk_set][w] || (asid_q[w_lk_set][w] == lk_asid);
`else
         w_asid_ok[w] = 1'b1;
`endif
         w_match[w] = valid_q[w_lk_set][w] && (vpn_q[w_lk_set][w] == lk_vpn) && w_asid_ok[w];
      end
   end

   // Lowest matching way wins
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (w_match[w]) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   // Per-set replacement; a fill to the same set overrides the hit's touch
   generate
      for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
         logic w_fill_here, w_hit_here;
         assign w_fill_here = w_fill_fire && (w_fill_set == SET_W'(s));
         assign w_hit_here  = w_lk_fire && w_hit && (w_lk_set == SET_W'(s));
         tlb_age_lru #(
            .NUM_WAYS (NUM_WAYS),
            .WAY_W    (WAY_W)
         ) u_lru (
            .valid_i   (valid_q[s]),
            .ages_i    (age_q[s]),
            .touch_i   (w_fill_here || w_hit_here),
            .is_fill_i (w_fill_here),
            .way_i     (w_fill_here ? w_victim[s] : w_hit_way),
            .victim_o  (w_victim[s]),
            .ages_o    (age_d[s])
         );
      end
   endgenerate

   // Ways cleared in the set currently being swept
   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef TLB_ASID_EN
         w_inv_mask[w] = !by_asid_q ||
                         (!glob_q[sweep_q][w] && (asid_q[sweep_q][w] == fl_asid_q));
`else
         w_inv_mask[w] = 1'b1;
`endif
      end
   end

   // Valid bits and ages: fills set a valid bit, the sweep clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            age_q[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SETS; s++) begin
            age_q[s] <= age_d[s];
         end
         if (w_fill_fire) begin
            valid_q[w_fill_set][w_fill_victim] <= 1'b1;
         end
         if (state_q == FL_SWEEP) begin
            valid_q[sweep_q] <= valid_q[sweep_q] & ~w_inv_mask;
         end
      end
   end

   // Entry payload, gated by its valid bit so it needs no reset
   always_ff @(posedge clk) begin
      if (w_fill_fire) begin
         vpn_q[w_fill_set][w_fill_victim]   <= fill_vpn;
         ppn_q[w_fill_set][w_fill_victim]   <= fill_ppn;
         perms_q[w_fill_set][w_fill_victim] <= fill_perms;
`ifdef TLB_ASID_EN
         asid_q[w_fill_set][w_fill_victim]  <= fill_asid;
         glob_q[w_fill_set][w_fill_victim]  <= fill_global;
`endif
      end
   end

   // Flush sweep state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FL_IDLE;
         sweep_q   <= '0;
         done_q    <= 1'b0;
`ifdef TLB_ASID_EN
         by_asid_q <= 1'b0;
         fl_asid_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         done_q    <= done_d;
`ifdef TLB_ASID_EN
         by_asid_q <= by_asid_d;
         fl_asid_q <= fl_asid_d;
`endif
      end
   end

   // Flush sweep next state: one set per cycle, done pulse after the last set
   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      done_d    = 1'b0;
`ifdef TLB_ASID_EN
      by_asid_d = by_asid_q;
      fl_asid_d = fl_asid_q;
`endif
      case (state_q)
         FL_IDLE: begin
            if (flush_req) begin
               state_d   = FL_SWEEP;
               sweep_d   = '0;
`ifdef TLB_ASID_EN
               by_asid_d = flush_by_asid;
               fl_asid_d = flush_asid;
`endif
            end
         end
         FL_SWEEP: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == SET_W'(NUM_SETS - 1)) begin
               state_d = FL_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = FL_IDLE;
      endcase
   end

   // Registered lookup response, zeroed on miss
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_ppn_q   <= '0;
         rsp_perms_q <= '0;
      end else begin
         rsp_valid_q <= w_lk_fire;
         rsp_hit_q   <= w_lk_fire && w_hit;
         rsp_way_q   <= (w_lk_fire && w_hit) ? w_hit_way : '0;
         rsp_ppn_q   <= (w_lk_fire && w_hit) ? ppn_q[w_lk_set][w_hit_way] : '0;
         rsp_perms_q <= (w_lk_fire && w_hit) ? perms_q[w_lk_set][w_hit_way] : '0;
      end
   end

   assign lk_ready   = w_idle;
   assign flush_busy = (state_q == FL_SWEEP);
   assign flush_done = done_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_hit    = rsp_hit_q;
   assign rsp_way    = rsp_way_q;
   assign rsp_ppn    = rsp_ppn_q;
   assign rsp_perms  = rsp_perms_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_way_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlb_way_array
// Brief   : Self-checking bench for tlb_way_array with a transaction-level
//           reference model; directed scenarios followed by random traffic.
//           ASID-specific scenario compiled when TLB_ASID_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tlb_way_array;

   localparam int NS = 16;
   localparam int NW = 4;

   logic        clk = 1'b0;
   logic        rst, lk_valid, lk_ready, rsp_valid, rsp_hit;
   logic [19:0] lk_vpn, fill_vpn, fill_ppn, rsp_ppn;
   logic [7:0]  lk_asid, fill_asid, flush_asid;
   logic [1:0]  rsp_way, rsp_perms, fill_perms;
   logic        fill_en, fill_global, flush_req, flush_by_asid, flush_busy, flush_done;

   always #5 clk = ~clk;

   tlb_way_array dut (
      .clk(clk), .rst(rst),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_vpn(lk_vpn), .lk_asid(lk_asid),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
      .rsp_ppn(rsp_ppn), .rsp_perms(rsp_perms),
      .fill_en(fill_en), .fill_vpn(fill_vpn), .fill_asid(fill_asid),
      .fill_global(fill_global), .fill_ppn(fill_ppn), .fill_perms(fill_perms),
      .flush_req(flush_req), .flush_by_asid(flush_by_asid), .flush_asid(flush_asid),
      .flush_busy(flush_busy), .flush_done(flush_done)
   );

   // Reference model: entry table, ages, sweep progress
   bit          m_valid [NS][NW];
   logic [19:0] m_vpn   [NS][NW];
   logic [19:0] m_ppn   [NS][NW];
   logic [1:0]  m_perm  [NS][NW];
   logic [7:0]  m_asid  [NS][NW];
   bit          m_glob  [NS][NW];
   int          m_age   [NS][NW];
   bit          m_sweep, m_done, m_by;
   int          m_sset;
   logic [7:0]  m_fasid;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit asid_ok(int s, int w, logic [7:0] a);
`ifdef TLB_ASID_EN
      return m_glob[s][w] || (m_asid[s][w] == a);
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit flush_hits(int s, int w);
`ifdef TLB_ASID_EN
      return !m_by || (!m_glob[s][w] && (m_asid[s][w] == m_fasid));
`else
      return 1'b1;
`endif
   endfunction

   // Make way w of set s youngest; valid ways younger than 'old' age by one
   task automatic touch(int s, int w, int old);
      for (int i = 0; i < NW; i++)
         if (i != w && m_valid[s][i] && m_age[s][i] < old) m_age[s][i]++;
      m_age[s][w] = 0;
   endtask

   // One clock: predict from current inputs, advance, compare
   task automatic cycle();
      bit          e_rv, e_hit, lk, fl, hit;
      int          e_way, ls, fs, hw, vw;
      logic [19:0] e_ppn;
      logic [1:0]  e_perm;
      e_rv = 0; e_hit = 0; e_way = 0; e_ppn = '0; e_perm = '0;
      if (rst) begin
         for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
               m_valid[s][w] = 0;
               m_age[s][w]   = 0;
            end
         m_sweep = 0;
         m_done  = 0;
      end else begin
         lk = lk_valid && !m_sweep;
         fl = fill_en && !m_sweep;
         ls = lk_vpn % NS;
         fs = fill_vpn % NS;
         hit = 0; hw = 0;
         if (lk)
            for (int w = NW - 1; w >= 0; w--)
               if (m_valid[ls][w] && m_vpn[ls][w] == lk_vpn && asid_ok(ls, w, lk_asid)) begin
                  hit = 1; hw = w;
               end
         e_rv = lk;
         if (hit) begin
            e_hit = 1; e_way = hw; e_ppn = m_ppn[ls][hw]; e_perm = m_perm[ls][hw];
         end
         if (fl) begin
            vw = -1;
            for (int w = 0; w < NW; w++) if (vw < 0 && !m_valid[fs][w]) vw = w;
            for (int w = 0; w < NW; w++) if (vw < 0 && m_age[fs][w] == NW - 1) vw = w;
            if (vw < 0) vw = 0;
            touch(fs, vw, NW - 1);
            m_valid[fs][vw] = 1;
            m_vpn[fs][vw]   = fill_vpn;
            m_ppn[fs][vw]   = fill_ppn;
            m_perm[fs][vw]  = fill_perms;
            m_asid[fs][vw]  = fill_asid;
            m_glob[fs][vw]  = fill_global;
         end
         if (hit && !(fl && fs == ls)) touch(ls, hw, m_age[ls][hw]);
         if (m_sweep) begin
            for (int w = 0; w < NW; w++) if (flush_hits(m_sset, w)) m_valid[m_sset][w] = 0;
            if (m_sset == NS - 1) begin
               m_sweep = 0; m_done = 1;
            end else begin
               m_sset++; m_done = 0;
            end
         end else begin
            m_done = 0;
            if (flush_req) begin
               m_sweep = 1; m_sset = 0; m_by = flush_by_asid; m_fasid = flush_asid;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv || rst)
         chk("rsp_data", {rsp_hit, rsp_way, rsp_ppn, rsp_perms},
             {e_hit, e_way[1:0], e_ppn, e_perm});
      chk("busy_done_ready", {flush_busy, flush_done, lk_ready}, {m_sweep, m_done, !m_sweep});
   endtask

   task automatic do_fill(logic [19:0] v, logic [19:0] p, logic [7:0] a, bit g);
      fill_en = 1; fill_vpn = v; fill_ppn = p; fill_asid = a; fill_global = g;
      fill_perms = 2'(v[1:0] ^ 2'b10);
      cycle();
      fill_en = 0;
   endtask

   task automatic do_lookup(logic [19:0] v, logic [7:0] a);
      lk_valid = 1; lk_vpn = v; lk_asid = a;
      cycle();
      lk_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic count_sweep(output int n_busy, output bit seen_done);
      n_busy    = flush_busy ? 1 : 0;
      seen_done = 0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
         cycle();
         if (flush_busy) n_busy++;
         if (flush_done) seen_done = 1;
      end
   endtask

   initial begin
      int n_busy;
      bit seen_done;
      rst = 1; lk_valid = 0; lk_vpn = '0; lk_asid = '0;
      fill_en = 0; fill_vpn = '0; fill_asid = '0; fill_global = 0; fill_ppn = '0; fill_perms = '0;
      flush_req = 0; flush_by_asid = 0; flush_asid = '0;
      m_sweep = 0; m_done = 0; m_by = 0; m_sset = 0; m_fasid = '0;

      cycle();
      cycle();
      rst = 0;
      chk("reset_lk_ready", lk_ready, 1'b1);
      chk("reset_busy", flush_busy, 1'b0);

      // Basic fill then lookup
      do_fill(20'h00013, 20'hABCDE, 8'd5, 0);
      do_lookup(20'h00013, 8'd5);
      chk("basic_hit", rsp_hit, 1'b1);
      chk("basic_ppn", rsp_ppn, 20'hABCDE);

      // Five fills into set 3: first one evicted
      do_reset();
      for (int k = 0; k < 5; k++) do_fill(20'(3 + 16 * k), 20'(100 + k), 8'd1, 0);
      do_lookup(20'h00003, 8'd1);
      chk("evict_first_miss", rsp_hit, 1'b0);
      for (int k = 1; k < 5; k++) begin
         do_lookup(20'(3 + 16 * k), 8'd1);
         chk("evict_others_hit", rsp_hit, 1'b1);
      end

      // Hit way 0 then fill: way 1 is the victim
      do_reset();
      for (int k = 0; k < 4; k++) do_fill(20'(3 + 16 * k), 20'(200 + k), 8'd1, 0);
      do_lookup(20'h00003, 8'd1);
      chk("lru_hit_way0", {rsp_hit, rsp_way}, {1'b1, 2'd0});
      do_fill(20'h00053, 20'h12345, 8'd1, 0);
      do_lookup(20'h00053, 8'd1);
      chk("lru_new_in_way1", {rsp_hit, rsp_way}, {1'b1, 2'd1});
      do_lookup(20'h00013, 8'd1);
      chk("lru_way1_evicted", rsp_hit, 1'b0);

      // Fill and lookup of the same VPN in one cycle: lookup sees pre-fill
      do_reset();
      lk_valid = 1; lk_vpn = 20'h00005; lk_asid = 8'd2;
      do_fill(20'h00005, 20'h0BEEF, 8'd2, 0);
      lk_valid = 0;
      chk("same_cycle_miss", rsp_hit, 1'b0);
      do_lookup(20'h00005, 8'd2);
      chk("same_cycle_later_hit", rsp_hit, 1'b1);

      // Fill and flush request together, then a full sweep
      flush_req = 1;
      do_fill(20'h00027, 20'h00777, 8'd2, 0);
      flush_req = 0;
      count_sweep(n_busy, seen_done);
      chk("sweep_busy_cycles", n_busy, 16);
      chk("sweep_done_seen", seen_done, 1'b1);
      do_lookup(20'h00027, 8'd2);
      chk("sweep_cleared", rsp_hit, 1'b0);

`ifdef TLB_ASID_EN
      // Selective flush keeps global entries and other ASIDs
      do_reset();
      do_fill(20'h00021, 20'h00A05, 8'd5, 0);
      do_fill(20'h00042, 20'h00A07, 8'd7, 1);
      flush_req = 1; flush_by_asid = 1; flush_asid = 8'd5;
      cycle();
      flush_req = 0; flush_by_asid = 0;
      count_sweep(n_busy, seen_done);
      chk("asid_busy_cycles", n_busy, 16);
      chk("asid_done_seen", seen_done, 1'b1);
      do_lookup(20'h00021, 8'd5);
      chk("asid_flushed_miss", rsp_hit, 1'b0);
      do_lookup(20'h00042, 8'd9);
      chk("asid_global_hit", rsp_hit, 1'b1);
`endif

      // Reset in the middle of a sweep aborts it silently
      do_fill(20'h0000E, 20'h00E0E, 8'd3, 0);
      flush_req = 1;
      cycle();
      flush_req = 0;
      for (int i = 0; i < 6; i++) cycle();
      chk("abort_busy_before", flush_busy, 1'b1);
      do_reset();
      chk("abort_busy_after", flush_busy, 1'b0);
      chk("abort_ready", lk_ready, 1'b1);
      for (int i = 0; i < 20; i++) cycle();
      do_lookup(20'h0000E, 8'd3);
      chk("abort_miss", rsp_hit, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         lk_valid      = ($urandom_range(0, 1) == 1);
         lk_vpn        = 20'($urandom_range(0, 63));
         lk_asid       = 8'($urandom_range(0, 3));
         fill_en       = ($urandom_range(0, 2) == 0);
         fill_vpn      = 20'($urandom_range(0, 63));
         fill_asid     = 8'($urandom_range(0, 3));
         fill_global   = ($urandom_range(0, 3) == 0);
         fill_ppn      = 20'($urandom);
         fill_perms    = 2'($urandom_range(0, 3));
         flush_req     = ($urandom_range(0, 99) == 0);
         flush_by_asid = ($urandom_range(0, 1) == 1);
         flush_asid    = 8'($urandom_range(0, 3));
         cycle();
      end
      lk_valid = 0; fill_en = 0; flush_req = 0;
      for (int i = 0; i < 20; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tlb_way_array.md
TLB_WAY_ARRAY -- requirements
Module: tlb_way_array

Interface
REQ-001 SHALL provide parameter NUM_SETS, default 16, number of sets (power of two, >=2).
REQ-002 SHALL provide parameter NUM_WAYS, default 4, associativity (power of two, 2..8).
REQ-003 SHALL provide parameter VPN_W, default 20, virtual page number width.
REQ-004 SHALL provide parameter PPN_W, default 20, physical page number width.
REQ-005 SHALL provide parameter ASID_W, default 8, address-space identifier width.
REQ-006 SHALL provide ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted when lk_valid and lk_ready.
- lk_vpn  in  VPN_W  lookup VPN.
- lk_asid  in  ASID_W  lookup ASID.
- rsp_valid  out  1  response strobe.
- rsp_hit  out  1  hit flag.
- rsp_way  out  log2(NUM_WAYS)  hit way.
- rsp_ppn  out  PPN_W  translated PPN.
- rsp_perms  out  2  permission bits.
- fill_en  in  1  fill request.
- fill_vpn  in  VPN_W  fill VPN.
- fill_asid  in  ASID_W  fill ASID.
- fill_global  in  1  entry matches any ASID.
- fill_ppn  in  PPN_W  fill PPN.
- fill_perms  in  2  fill permissions.
- flush_req  in  1  start invalidation sweep.
- flush_by_asid  in  1  sweep only non-global entries matching flush_asid.
- flush_asid  in  ASID_W  ASID for selective flush.
- flush_busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse at sweep end.

Function
REQ-007 Set index SHALL be the low log2(NUM_SETS) bits of the VPN; full VPN is stored as tag.
REQ-008 Lookup SHALL have one-cycle latency: accepted in cycle N, rsp_* valid in N+1 for exactly one cycle.
REQ-009 Hit SHALL require valid, VPN equal, and (global or ASID equal); multiple matches SHALL select lowest way.
REQ-010 On miss rsp_hit, rsp_way, rsp_ppn, rsp_perms SHALL be 0.
REQ-011 Replacement age per entry SHALL be log2(NUM_WAYS) bits; 0 = most recent.
REQ-012 On hit or fill of way W, age[W] SHALL become 0 and every valid way with age < old age[W] SHALL increment; a fill counts old age of its victim as NUM_WAYS-1.
REQ-013 Fill victim SHALL be the lowest-numbered invalid way, else the way with age NUM_WAYS-1; fill writes take effect at end of the fill_en cycle.
REQ-014 Fill and lookup in the same cycle SHALL give the lookup the pre-fill contents; if both touch the same set, the fill's age update SHALL apply and the hit's age update SHALL be dropped.
REQ-015 Flush FSM SHALL have states IDLE and SWEEP; flush_req in IDLE enters SWEEP, visiting set 0..NUM_SETS-1 one set per cycle, invalidating all ways (or matching ways when flush_by_asid latched at start).
REQ-016 After the last set, FSM SHALL return to IDLE and pulse flush_done one cycle; flush_busy SHALL be high exactly during SWEEP (NUM_SETS cycles).
REQ-017 lk_ready SHALL be 0 during SWEEP and 1 otherwise; fill_en and flush_req during SWEEP SHALL be ignored.
REQ-018 flush_req and fill_en in the same IDLE cycle: fill SHALL complete, then sweep SHALL start next cycle.

Reset
REQ-019 rst SHALL clear all valid bits and ages, return FSM to IDLE (aborting any sweep without flush_done), and drive rsp_valid, rsp_hit, rsp_way, rsp_ppn, rsp_perms, flush_busy, flush_done to 0, lk_ready to 1.

Configuration
REQ-020 Macro TLB_ASID_EN SHALL compile in ASID and global storage and matching; without it, ASID/global inputs SHALL be ignored, every entry matches any ASID, and flush_by_asid SHALL perform a full flush.

Structure
REQ-021 Shared package tlb_pkg SHALL hold perms encoding, default widths and the log2 helper constant.
REQ-022 Victim/age computation SHALL be a sub-module tlb_age_lru (per-set ages in, victim and next ages out).

Verification
REQ-023 Fill VPN 0x00013, PPN 0xABCDE, ASID 5; lookup VPN 0x00013 ASID 5 -> next cycle rsp_hit=1, rsp_ppn=0xABCDE.
REQ-024 Fill 5 VPNs mapping to set 3 (4 ways), no intermediate hits -> first-filled VPN misses, other four hit.
REQ-025 Fill set 3 ways 0..3, hit way 0, fill new VPN to set 3 -> way 1 replaced.
REQ-026 With TLB_ASID_EN: fill ASID 5 non-global and ASID 7 global, flush_by_asid ASID 5 -> flush_busy 16 cycles, flush_done pulse, ASID 5 entry misses, global entry hits.
REQ-027 Assert rst at sweep cycle 6 -> flush_busy=0, no flush_done, all lookups miss, lk_ready=1.
